// File: rtl/bus_resp_pkg.sv
// bus_resp_pkg: shared definitions for the bus responder slice.
//   - register addresses (TX FIFO, STATUS, TIMER)
//   - STATUS bit positions
//   - bus request struct (addr, rd, wr, wdata)
//   - address-region enum produced by the responder's decoder
package bus_resp_pkg;

    localparam logic [7:0] ADDR_FIFO   = 8'h80;
    localparam logic [7:0] ADDR_STATUS = 8'h81;
    localparam logic [7:0] ADDR_TIMER  = 8'h82;

    localparam int unsigned ST_EMPTY     = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_COUNT_LSB = 2;
    localparam int unsigned ST_COUNT_MSB = 4;
    localparam int unsigned ST_OVF       = 5;

    typedef struct packed {
        logic [7:0]  addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
    } bus_req_t;

    typedef enum logic [2:0] {
        RGN_RAM,
        RGN_FIFO,
        RGN_STATUS,
        RGN_TIMER,
        RGN_NONE
    } region_t;

endpackage

// File: rtl/bus_responder_tx_fifo.sv
// tx_fifo: synchronous FIFO with a separate occupancy count so full and
// empty are never ambiguous.
//   CLK, RST_N     : clock, asynchronous active-low reset
//   push, din      : write request / data (dropped when full without pop)
//   pop            : read request (ignored when empty)
//   dout           : head entry, 0 when empty
//   count          : occupancy 0..DEPTH
//   full, empty    : status flags
//   dropped        : one-cycle flag when a push was discarded
module tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       dropped
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A pop frees the slot being written, so a full FIFO still accepts
    // a push in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dropped = push & full & ~do_pop;

    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bus_responder.sv
// bus_responder: bus slave for the accumulator controller.
//   Map: 0x00..RAM_WORDS-1 scratch RAM, 0x80 TX FIFO, 0x81 STATUS (W1C
//   overflow), 0x82 TIMER (only when BUS_RESPONDER_TIMER_EN is defined).
//   CLK, RST_N        : clock, asynchronous active-low reset
//   addr, rd, wr      : word address and request strobes
//   wdata             : write data
//   rdata             : registered read data (1-cycle latency, held)
//   tx_data, tx_valid : TX FIFO head / not-empty
//   tx_ready          : sink accepts head (pop on tx_valid & tx_ready)
//   err               : one-cycle pulse for an illegal access
module bus_responder #(
    parameter int unsigned RAM_WORDS  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        err
);

    import bus_resp_pkg::*;

    localparam int unsigned RAW = $clog2(RAM_WORDS);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

    bus_req_t          req;
    region_t           rgn;
    logic              illegal;
    logic              wr_ok;
    logic [31:0]       rd_val;
    logic [31:0]       status;
    logic              overflow;
    logic [31:0]       ram [RAM_WORDS];
    logic [RAW-1:0]    ram_idx;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_dropped;
    logic [CW-1:0]     fifo_count;

    assign req = '{addr: addr, rd: rd, wr: wr, wdata: wdata};

    always_comb begin
        rgn = RGN_NONE;
        if ({24'b0, req.addr} < RAM_WORDS)
            rgn = RGN_RAM;
        else if (req.addr == ADDR_FIFO)
            rgn = RGN_FIFO;
        else if (req.addr == ADDR_STATUS)
            rgn = RGN_STATUS;
`ifdef BUS_RESPONDER_TIMER_EN
        else if (req.addr == ADDR_TIMER)
            rgn = RGN_TIMER;
`endif
    end

    assign illegal = (req.rd | req.wr) & ((rgn == RGN_NONE) | (req.rd & req.wr));
    assign wr_ok   = req.wr & ~illegal;
    assign ram_idx = req.addr[RAW-1:0];

    assign fifo_push = wr_ok & (rgn == RGN_FIFO);
    assign fifo_pop  = tx_valid & tx_ready;
    assign tx_valid  = ~fifo_empty;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_tx_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (req.wdata),
        .dout    (tx_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .dropped (fifo_dropped)
    );

    always_comb begin
        status                            = '0;
        status[ST_EMPTY]                  = fifo_empty;
        status[ST_FULL]                   = fifo_full;
        status[ST_COUNT_MSB:ST_COUNT_LSB] = 3'(fifo_count);
        status[ST_OVF]                    = overflow;
    end

`ifdef BUS_RESPONDER_TIMER_EN
    logic [31:0] timer;

    // The write cycle itself counts, so the loaded value is already
    // advanced by one when it is first readable.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            timer <= '0;
        else if (wr_ok && rgn == RGN_TIMER)
            timer <= req.wdata + 32'd1;
        else
            timer <= timer + 32'd1;
    end
`endif

    always_comb begin
        rd_val = '0;
        case (rgn)
            RGN_RAM:    rd_val = ram[ram_idx];
            RGN_FIFO:   rd_val = tx_data;
            RGN_STATUS: rd_val = status;
`ifdef BUS_RESPONDER_TIMER_EN
            RGN_TIMER:  rd_val = timer;
`endif
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (wr_ok && rgn == RGN_RAM)
            ram[ram_idx] <= req.wdata;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rdata    <= '0;
            err      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            err <= illegal;
            if (req.rd)
                rdata <= illegal ? '0 : rd_val;
            if (fifo_dropped)
                overflow <= 1'b1;
            else if (wr_ok && rgn == RGN_STATUS && req.wdata[ST_OVF])
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
module tb_bus_responder;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        CLK;
    logic        RST_N;
    logic [7:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        err;

    int          tests_run;
    int          fails;
    string       cur;
    exp_t        exp_q[$];
    logic [31:0] tx_q[$];
    logic [31:0] held;
    logic [31:0] ram_pat [16];

    bus_responder #(
        .RAM_WORDS  (16),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .addr     (addr),
        .rd       (rd),
        .wr       (wr),
        .wdata    (wdata),
        .rdata    (rdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .err      (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One bus cycle: at the negedge, score the previous cycle's rdata/err
    // against the scoreboard, then drive new inputs and queue the
    // expectation for them.
    task automatic cyc(input logic r, input logic w, input logic [7:0] a,
                       input logic [31:0] d, input logic [31:0] rexp,
                       input logic eexp, input logic rdy);
        exp_t e;
        @(negedge CLK);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (rdata !== e.rdata) begin
                fails++;
                $display("FAIL %s rdata: got %08h expected %08h", cur, rdata, e.rdata);
            end
            tests_run++;
            if (err !== e.err) begin
                fails++;
                $display("FAIL %s err: got %b expected %b", cur, err, e.err);
            end
        end
        rd = r; wr = w; addr = a; wdata = d; tx_ready = rdy;
        if (r)
            held = rexp;
        exp_q.push_back('{rdata: held, err: eexp});
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, rdy);
    endtask

    task automatic wr_op(input logic [7:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, a, d, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic rd_op(input logic [7:0] a, input logic [31:0] x);
        cyc(1'b1, 1'b0, a, 32'h0, x, 1'b0, 1'b0);
    endtask

    task automatic push_fifo(input logic [31:0] d);
        wr_op(8'h80, d);
        tx_q.push_back(d);
    endtask

    // Pop n entries through tx_ready, checking each head before it leaves,
    // then confirm the FIFO is empty.
    task automatic test_drain(input int n);
        logic [31:0] x;
        for (int i = 0; i < n; i++) begin
            idle(1'b1);
            x = (tx_q.size() > 0) ? tx_q.pop_front() : 32'hXXXX_XXXX;
            tests_run++;
            if (tx_valid !== 1'b1 || tx_data !== x) begin
                fails++;
                $display("FAIL %s tx head %0d: got valid=%b data=%08h expected valid=1 data=%08h",
                         cur, i, tx_valid, tx_data, x);
            end
        end
        idle(1'b0);
        tests_run++;
        if (tx_valid !== 1'b0 || tx_data !== 32'h0) begin
            fails++;
            $display("FAIL %s tx empty: got valid=%b data=%08h expected valid=0 data=0",
                     cur, tx_valid, tx_data);
        end
    endtask

    task automatic test_reset();
        cur = "reset";
        RST_N = 1'b0; rd = 0; wr = 0; addr = 0; wdata = 0; tx_ready = 0;
        held = 32'h0;
        repeat (2) @(negedge CLK);
        tests_run++;
        if (rdata !== 32'h0 || err !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 32'h0) begin
            fails++;
            $display("FAIL reset outputs: got rdata=%08h err=%b tx_valid=%b tx_data=%08h expected all 0",
                     rdata, err, tx_valid, tx_data);
        end
        RST_N = 1'b1;
        rd_op(8'h81, 32'h0000_0001);
        idle(1'b0);
    endtask

    task automatic test_ram();
        cur = "ram";
        wr_op(8'h05, 32'hDEAD_BEEF);
        rd_op(8'h05, 32'hDEAD_BEEF);
        repeat (3) idle(1'b0);
        wr_op(8'h0F, 32'h0F0F_1234);
        rd_op(8'h0F, 32'h0F0F_1234);
        cyc(1'b1, 1'b0, 8'h10, 32'h0, 32'h0, 1'b1, 1'b0);
        rd_op(8'h05, 32'hDEAD_BEEF);
        idle(1'b0);
    endtask

    task automatic test_illegal();
        cur = "illegal";
        cyc(1'b1, 1'b0, 8'h40, 32'h0, 32'h0, 1'b1, 1'b0);
        idle(1'b0);
        wr_op(8'h03, 32'h1234_5678);
        rd_op(8'h03, 32'h1234_5678);
        cyc(1'b1, 1'b1, 8'h03, 32'hAAAA_5555, 32'h0, 1'b1, 1'b0);
        idle(1'b0);
        rd_op(8'h03, 32'h1234_5678);
        cyc(1'b0, 1'b1, 8'h90, 32'h1111_1111, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 8'h83, 32'h2222_2222, 32'h0, 1'b1, 1'b0);
        idle(1'b0);
        rd_op(8'h81, 32'h0000_0001);
        idle(1'b0);
    endtask

    task automatic test_fifo_overflow();
        cur = "fifo_overflow";
        push_fifo(32'h11); push_fifo(32'h22); push_fifo(32'h33); push_fifo(32'h44);
        wr_op(8'h80, 32'h55);
        rd_op(8'h81, 32'h0000_0032);
        rd_op(8'h80, 32'h0000_0011);
        test_drain(4);
        rd_op(8'h81, 32'h0000_0021);
        wr_op(8'h81, 32'hFFFF_FFDF);
        rd_op(8'h81, 32'h0000_0021);
        wr_op(8'h81, 32'h0000_0020);
        rd_op(8'h81, 32'h0000_0001);
        rd_op(8'h80, 32'h0000_0000);
        idle(1'b0);
    endtask

    task automatic test_full_pushpop();
        logic [31:0] x;
        cur = "full_pushpop";
        push_fifo(32'hA0); push_fifo(32'hA1); push_fifo(32'hA2); push_fifo(32'hA3);
        cyc(1'b0, 1'b1, 8'h80, 32'h66, 32'h0, 1'b0, 1'b1);
        x = tx_q.pop_front();
        tx_q.push_back(32'h66);
        tests_run++;
        if (tx_valid !== 1'b1 || tx_data !== x) begin
            fails++;
            $display("FAIL full_pushpop head: got valid=%b data=%08h expected valid=1 data=%08h",
                     tx_valid, tx_data, x);
        end
        rd_op(8'h81, 32'h0000_0012);
        test_drain(4);
        cur = "empty_pushpop";
        cyc(1'b0, 1'b1, 8'h80, 32'h77, 32'h0, 1'b0, 1'b1);
        tx_q.push_back(32'h77);
        idle(1'b0);
        rd_op(8'h81, 32'h0000_0004);
        test_drain(1);
    endtask

    task automatic test_timer();
        cur = "timer";
`ifdef BUS_RESPONDER_TIMER_EN
        wr_op(8'h82, 32'hFFFF_FFFE);
        rd_op(8'h82, 32'hFFFF_FFFF);
        rd_op(8'h82, 32'h0000_0000);
`else
        cyc(1'b1, 1'b0, 8'h82, 32'h0, 32'h0, 1'b1, 1'b0);
`endif
        idle(1'b0);
    endtask

    task automatic test_back_to_back();
        cur = "back_to_back";
        for (int i = 0; i < 16; i++) begin
            ram_pat[i] = $urandom;
            wr_op(8'(i), ram_pat[i]);
        end
        for (int i = 0; i < 16; i++)
            rd_op(8'(i), ram_pat[i]);
        idle(1'b0);
    endtask

    task automatic test_reset_midop();
        cur = "reset_midop";
        push_fifo(32'hB1);
        push_fifo(32'hB2);
        rd_op(8'h80, 32'hB1);
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        tests_run++;
        if (tx_valid !== 1'b0 || tx_data !== 32'h0 || rdata !== 32'h0 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_midop async: got tx_valid=%b tx_data=%08h rdata=%08h err=%b expected all 0",
                     tx_valid, tx_data, rdata, err);
        end
        exp_q.delete();
        tx_q.delete();
        held = 32'h0;
        @(negedge CLK);
        rd = 0; wr = 0; tx_ready = 0;
        RST_N = 1'b1;
        rd_op(8'h81, 32'h0000_0001);
        rd_op(8'h07, ram_pat[7]);
        idle(1'b0);
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        test_reset();
        test_ram();
        test_illegal();
        test_fifo_overflow();
        test_full_pushpop();
        test_timer();
        test_back_to_back();
        test_reset_midop();
        idle(1'b0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
